// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and helpers for the DRAM arbiter.
//   state_e : arbiter FSM states
//   op_e    : latched operation type
//   clog2   : ceil(log2(n)), used to size the pointer, index and wait counter
package dram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: bundles the core-side request/ack bus and the DRAM port.
//   core side : i_req_rd, i_req_wr, i_addr, i_wdata -> o_ack, o_rdata, o_grant, o_busy
//   DRAM side : o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr <- i_mem_rdata
// Modports: slave = the arbiter, master = whatever drives the cores and models the DRAM.
interface dram_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8
);
    logic [NUM_CORES-1:0]        i_req_rd;
    logic [NUM_CORES-1:0]        i_req_wr;
    logic [NUM_CORES*ADDR_W-1:0] i_addr;
    logic [NUM_CORES*DATA_W-1:0] i_wdata;
    logic [NUM_CORES-1:0]        o_ack;
    logic [DATA_W-1:0]           o_rdata;
    logic [NUM_CORES-1:0]        o_grant;
    logic                        o_busy;
    logic [ADDR_W-1:0]           o_mem_addr;
    logic [DATA_W-1:0]           o_mem_wdata;
    logic                        o_mem_rd;
    logic                        o_mem_wr;
    logic [DATA_W-1:0]           i_mem_rdata;

    modport slave (
        input  i_req_rd, i_req_wr, i_addr, i_wdata, i_mem_rdata,
        output o_ack, o_rdata, o_grant, o_busy,
        output o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr
    );

    modport master (
        output i_req_rd, i_req_wr, i_addr, i_wdata, i_mem_rdata,
        input  o_ack, o_rdata, o_grant, o_busy,
        input  o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr
    );
endinterface

// File: rtl/dram_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection.
//   req   : request vector
//   ptr   : index with highest priority this round
//   mask  : requests to ignore this cycle
//   found : at least one unmasked request
//   idx   : first unmasked requester at or after ptr, wrapping
module rr_picker
    import dram_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    input  logic [NUM_CORES-1:0] mask,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);
    localparam logic [IDX_W:0] N_L = (IDX_W+1)'(NUM_CORES);

    logic [NUM_CORES-1:0] eff;
    logic [NUM_CORES-1:0] rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;

    always_comb begin
        eff   = req & ~mask;
        // Shifting the doubled vector puts bit ptr at position 0 with wrap.
        rot   = NUM_CORES'({eff, eff} >> ptr);
        found = |rot;
        off   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (rot[i]) off = IDX_W'(i);
        // Rotate the offset back to an absolute index, modulo NUM_CORES.
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_L) sum = sum - N_L;
        idx = sum[IDX_W-1:0];
    end
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter sharing one single-port DRAM among
// NUM_CORES requesters. One transaction at a time: IDLE picks a winner,
// ISSUE pulses the DRAM strobe, WAIT covers MEM_LAT for reads, ACK pulses
// o_ack for one cycle.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : dram_arbiter_if.slave (core requests/acks + DRAM port)
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MEM_LAT   = 2
) (
    input logic           i_clk,
    input logic           i_rst,
    dram_arbiter_if.slave bus
);
    localparam int IDX_W = (clog2(NUM_CORES) < 1) ? 1 : clog2(NUM_CORES);
    localparam int CNT_W = (clog2(MEM_LAT) < 1) ? 1 : clog2(MEM_LAT);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CORES - 1);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [NUM_CORES-1:0] ONE      = NUM_CORES'(1);

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    state_e               state_q, state_d;
    txn_t                 txn_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [NUM_CORES-1:0] mask_q;
    logic [NUM_CORES-1:0] req;
    logic [NUM_CORES-1:0] own_oh;
    logic                 found;
    logic [IDX_W-1:0]     win_idx;

    assign req    = bus.i_req_rd | bus.i_req_wr;
    assign own_oh = ONE << txn_q.idx;

    rr_picker #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .mask  (mask_q),
        .found (found),
        .idx   (win_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.o_ack    = '0;
        bus.o_grant  = '0;
        bus.o_mem_rd = 1'b0;
        bus.o_mem_wr = 1'b0;
        case (state_q)
            ST_IDLE:  if (found) state_d = ST_ISSUE;
            ST_ISSUE: begin
                bus.o_mem_wr = (txn_q.op == OP_WR);
                bus.o_mem_rd = (txn_q.op == OP_RD);
                state_d      = (txn_q.op == OP_WR) ? ST_ACK : ST_WAIT;
            end
            ST_WAIT:  if (cnt_q == '0) state_d = ST_ACK;
            ST_ACK: begin
                bus.o_ack = own_oh;
                state_d   = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE) bus.o_grant = own_oh;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            txn_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            mask_q  <= '0;
        end else begin
            // The mask lives for exactly the IDLE cycle that follows ACK.
            mask_q <= '0;
            case (state_q)
                ST_IDLE: if (found) begin
                    txn_q.idx   <= win_idx;
                    // rd+wr together counts as a write
                    txn_q.op    <= bus.i_req_wr[win_idx] ? OP_WR : OP_RD;
                    txn_q.addr  <= bus.i_addr[win_idx*ADDR_W +: ADDR_W];
                    txn_q.wdata <= bus.i_wdata[win_idx*DATA_W +: DATA_W];
                end
                ST_ISSUE: cnt_q <= CNT_LOAD;
                ST_WAIT: begin
                    if (cnt_q == '0) rdata_q <= bus.i_mem_rdata;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                ST_ACK: begin
                    mask_q <= own_oh;
                    ptr_q  <= (txn_q.idx == LAST_IDX) ? '0 : txn_q.idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_rdata     = rdata_q;
    assign bus.o_mem_addr  = txn_q.addr;
    assign bus.o_mem_wdata = txn_q.wdata;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: vector table for single transactions, hand sequences for
// contention / mask / mid-read reset, then randomized traffic checked
// against a transaction-schedule model.
module tb_dram_arbiter;
    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    dram_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          core;
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  mem;
        bit          exp_wr;
        int          exp_lat;
        logic [3:0]  exp_ack;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[5];
    int   order[$];
    int   when_q[$];
    int   start_c, drop3, early, acks;

    // random-phase requesters and model
    bit          pend[N];
    bit          prd[N];
    bit          pwr[N];
    int          drop_at[N];
    logic [15:0] pa[N];
    logic [7:0]  pd[N];
    bit          act;
    int          t_start, t_ack, t_core, ptr_m, mask_core, mask_cyc, rd_due;
    bit          t_wr;
    logic [15:0] t_addr;
    logic [7:0]  t_data, exp_rd, rd_val;
    logic [3:0]  e_ack, e_grant, one4;
    bit          e_busy, e_rd, e_wr;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int idx_of(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic set_req(input int k, input bit rd, input bit wr,
                           input logic [15:0] a, input logic [7:0] d);
        bus.i_req_rd[k]          = rd;
        bus.i_req_wr[k]          = wr;
        bus.i_addr[k*AW +: AW]   = a;
        bus.i_wdata[k*DW +: DW]  = d;
    endtask

    task automatic clear_reqs();
        bus.i_req_rd = '0;
        bus.i_req_wr = '0;
        bus.i_addr   = '0;
        bus.i_wdata  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        bus.i_mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ack"},   32'(bus.o_ack), 0);
        check({tag, " grant"}, 32'(bus.o_grant), 0);
        check({tag, " busy"},  32'(bus.o_busy), 0);
        check({tag, " rd"},    32'(bus.o_mem_rd), 0);
        check({tag, " wr"},    32'(bus.o_mem_wr), 0);
        check({tag, " addr"},  32'(bus.o_mem_addr), 0);
        check({tag, " wdata"}, 32'(bus.o_mem_wdata), 0);
        check({tag, " rdata"}, 32'(bus.o_rdata), 0);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string tag;
        tag = $sformatf("vec%0d", n);
        early = 0;
        set_req(v.core, v.rd, v.wr, v.addr, v.wdata);
        bus.i_mem_rdata = 8'hEE;
        for (int c = 1; c <= v.exp_lat; c++) begin
            tick();
            if (c == 1) begin
                check({tag, " mem_wr"}, 32'(bus.o_mem_wr), 32'(v.exp_wr));
                check({tag, " mem_rd"}, 32'(bus.o_mem_rd), 32'(!v.exp_wr));
                check({tag, " mem_addr"}, 32'(bus.o_mem_addr), 32'(v.addr));
                if (v.exp_wr) check({tag, " mem_wdata"}, 32'(bus.o_mem_wdata), 32'(v.wdata));
                check({tag, " grant"}, 32'(bus.o_grant), 32'(v.exp_ack));
                check({tag, " busy"}, 32'(bus.o_busy), 1);
            end
            bus.i_mem_rdata = (c == 1 + LAT) ? v.mem : 8'hEE;
            if (c < v.exp_lat && bus.o_ack != 0) early++;
        end
        check({tag, " early ack"}, 32'(early), 0);
        check({tag, " ack"}, 32'(bus.o_ack), 32'(v.exp_ack));
        check({tag, " rdata"}, 32'(bus.o_rdata), 32'(v.exp_rdata));
        clear_reqs();
        tick();
        check({tag, " idle ack"}, 32'(bus.o_ack), 0);
        check({tag, " idle busy"}, 32'(bus.o_busy), 0);
        check({tag, " rdata hold"}, 32'(bus.o_rdata), 32'(v.exp_rdata));
        tick();
    endtask

    // Single write on core k; waits for its ack then leaves the arbiter idle.
    task automatic single_write(input int k);
        set_req(k, 1'b0, 1'b1, 16'h0BAD, 8'h11);
        acks = 0;
        for (int c = 0; c < 10 && acks == 0; c++) begin
            tick();
            if (bus.o_ack != 0) acks++;
        end
        check("setup write ack", 32'(acks), 1);
        clear_reqs();
        tick();
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        one4 = 4'b0001;
        vecs[0] = '{2, 1'b0, 1'b1, 16'h0123, 8'hA5, 8'h00, 1'b1, 2,       4'b0100, 8'h00};
        vecs[1] = '{1, 1'b1, 1'b0, 16'h0040, 8'h00, 8'h3C, 1'b0, LAT + 2, 4'b0010, 8'h3C};
        vecs[2] = '{0, 1'b1, 1'b1, 16'h1111, 8'h5A, 8'h99, 1'b1, 2,       4'b0001, 8'h3C};
        vecs[3] = '{3, 1'b1, 1'b0, 16'hFFFF, 8'h00, 8'hC3, 1'b0, LAT + 2, 4'b1000, 8'hC3};
        vecs[4] = '{3, 1'b0, 1'b1, 16'h0000, 8'hFF, 8'h00, 1'b1, 2,       4'b1000, 8'hC3};

        // reset values
        do_reset();
        check_all_zero("reset");

        // vector table
        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // contention: all cores write continuously
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b1, 16'h0100 + 16'(k), 8'h10 + 8'(k));
        start_c = cyc;
        order.delete();
        when_q.delete();
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            tick();
            if (bus.o_ack != 0) begin
                check("contention ack onehot", 32'($onehot(bus.o_ack)), 1);
                order.push_back(idx_of(bus.o_ack));
                when_q.push_back(cyc);
            end
        end
        check("contention ack count", 32'(order.size()), 5);
        if (when_q.size() > 0) check("contention first ack", 32'(when_q[0] - start_c), 2);
        for (int i = 0; i < order.size(); i++) begin
            check($sformatf("contention order %0d", i), 32'(order[i]), 32'(i % N));
            if (i > 0) check($sformatf("contention spacing %0d", i), 32'(when_q[i] - when_q[i-1]), 3);
        end
        clear_reqs();
        tick();
        tick();

        // mask and wrap: ptr=3, cores 3 and 0 request; core 3 holds one extra cycle
        do_reset();
        single_write(2);
        set_req(3, 1'b0, 1'b1, 16'h3333, 8'h33);
        set_req(0, 1'b0, 1'b1, 16'h0000, 8'h00);
        order.delete();
        when_q.delete();
        drop3 = -1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (cyc == drop3) set_req(3, 1'b0, 1'b0, 16'h0, 8'h0);
            if (bus.o_ack != 0) begin
                order.push_back(idx_of(bus.o_ack));
                when_q.push_back(cyc);
                if (bus.o_ack == 4'b1000) drop3 = cyc + 2;
                if (bus.o_ack == 4'b0001) set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
            end
        end
        check("wrap ack count", 32'(order.size()), 2);
        if (order.size() >= 2) begin
            check("wrap first", 32'(order[0]), 3);
            check("wrap second", 32'(order[1]), 0);
            check("wrap spacing", 32'(when_q[1] - when_q[0]), 3);
        end
        clear_reqs();

        // lone core holding one cycle past its ack must not be re-granted
        do_reset();
        set_req(1, 1'b0, 1'b1, 16'h0101, 8'h01);
        acks = 0;
        drop3 = -1;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (cyc == drop3) set_req(1, 1'b0, 1'b0, 16'h0, 8'h0);
            if (cyc == drop3 - 1) check("mask busy", 32'(bus.o_busy), 0);
            if (bus.o_ack != 0) begin
                acks++;
                if (drop3 < 0) drop3 = cyc + 2;
            end
        end
        check("mask ack count", 32'(acks), 1);
        clear_reqs();

        // reset mid-read
        do_reset();
        single_write(1);                       // ptr now 2
        set_req(1, 1'b1, 1'b0, 16'h0444, 8'h00);
        acks = 0;
        tick();                                // ISSUE
        if (bus.o_ack != 0) acks++;
        check("midrst issue rd", 32'(bus.o_mem_rd), 1);
        tick();                                // WAIT
        if (bus.o_ack != 0) acks++;
        rst = 1'b1;
        clear_reqs();
        bus.i_mem_rdata = 8'h77;
        tick();
        if (bus.o_ack != 0) acks++;
        check_all_zero("midrst");
        rst = 1'b0;
        set_req(0, 1'b0, 1'b1, 16'h0A0A, 8'h0A);
        set_req(2, 1'b0, 1'b1, 16'h0C0C, 8'h0C);
        order.delete();
        for (int c = 0; c < 10 && order.size() == 0; c++) begin
            tick();
            if (bus.o_ack != 0) order.push_back(idx_of(bus.o_ack));
        end
        check("midrst no ack during reset", 32'(acks), 0);
        check("midrst got ack", 32'(order.size()), 1);
        if (order.size() > 0) check("midrst first winner", 32'(order[0]), 0);
        clear_reqs();

        // randomized traffic against the schedule model
        do_reset();
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            drop_at[k] = -1;
        end
        act = 1'b0; t_ack = -1; t_start = -1; t_core = 0; t_wr = 1'b0;
        t_addr = '0; t_data = '0; ptr_m = 0; mask_core = -1; mask_cyc = -1;
        exp_rd = 8'h00; rd_due = -1; rd_val = '0;
        for (int n = 0; n < 1500; n++) begin
            tick();
            e_ack = '0; e_grant = '0; e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
            if (act && cyc > t_start && cyc <= t_ack) begin
                e_busy  = 1'b1;
                e_grant = one4 << t_core;
                e_wr    = t_wr && (cyc == t_start + 1);
                e_rd    = !t_wr && (cyc == t_start + 1);
                check("rand mem_addr", 32'(bus.o_mem_addr), 32'(t_addr));
                if (t_wr) check("rand mem_wdata", 32'(bus.o_mem_wdata), 32'(t_data));
                if (cyc == t_ack) begin
                    e_ack = one4 << t_core;
                    if (!t_wr) exp_rd = mem_fn(t_addr);
                end
            end
            check("rand ack",   32'(bus.o_ack),    32'(e_ack));
            check("rand grant", 32'(bus.o_grant),  32'(e_grant));
            check("rand busy",  32'(bus.o_busy),   32'(e_busy));
            check("rand rd",    32'(bus.o_mem_rd), 32'(e_rd));
            check("rand wr",    32'(bus.o_mem_wr), 32'(e_wr));
            check("rand rdata", 32'(bus.o_rdata),  32'(exp_rd));
            if (e_ack != 0) begin
                drop_at[t_core] = cyc + 2;
                ptr_m     = (t_core + 1) % N;
                mask_core = t_core;
                mask_cyc  = cyc + 1;
            end
            // DRAM model: data valid exactly MEM_LAT cycles after the strobe
            if (bus.o_mem_rd) begin
                rd_due = cyc + LAT;
                rd_val = mem_fn(bus.o_mem_addr);
            end
            bus.i_mem_rdata = (cyc == rd_due) ? rd_val : 8'($urandom);
            // requesters hold level requests until one cycle after their ack
            for (int k = 0; k < N; k++) begin
                if (pend[k] && cyc == drop_at[k]) begin
                    pend[k] = 1'b0;
                end else if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    pend[k]    = 1'b1;
                    drop_at[k] = -1;
                    case ($urandom_range(0, 2))
                        0:       begin prd[k] = 1'b1; pwr[k] = 1'b0; end
                        1:       begin prd[k] = 1'b0; pwr[k] = 1'b1; end
                        default: begin prd[k] = 1'b1; pwr[k] = 1'b1; end
                    endcase
                    pa[k] = 16'($urandom);
                    pd[k] = 8'($urandom);
                end
                if (pend[k]) set_req(k, prd[k], pwr[k], pa[k], pd[k]);
                else         set_req(k, 1'b0, 1'b0, 16'($urandom), 8'($urandom));
            end
            // model: pick the next transaction when the port is free
            if (!act || cyc > t_ack) begin
                act = 1'b0;
                for (int j = 0; j < N; j++) begin
                    int k;
                    k = (ptr_m + j) % N;
                    if (!act && pend[k] && !(k == mask_core && cyc == mask_cyc)) begin
                        act     = 1'b1;
                        t_start = cyc;
                        t_core  = k;
                        t_wr    = pwr[k];
                        t_addr  = pa[k];
                        t_data  = pd[k];
                        t_ack   = cyc + (pwr[k] ? 2 : 2 + LAT);
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Round-robin arbiter sharing one single-port DRAM between `NUM_CORES` matrix-multiplier cores. Each core presents a level-sensitive read or write request with address and write data. The arbiter serialises the requests onto the DRAM port, waits the fixed read latency, and returns a one-cycle acknowledge with read data. It sits between the cores' DRAM ports and the shared DRAM.

## Interface
Parameters:
- `NUM_CORES`, 4: number of requesters (≥2).
- `ADDR_W`, 16: DRAM address width.
- `DATA_W`, 8: DRAM data width.
- `MEM_LAT`, 2: cycles from the `o_mem_rd` cycle to valid `i_mem_rdata` (≥1).

Ports:
- `i_clk`  in  1: the single clock. All logic is on its rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_req_rd`  in  NUM_CORES: per-core read request (level).
- `i_req_wr`  in  NUM_CORES: per-core write request (level).
- `i_addr`  in  NUM_CORES*ADDR_W: per-core address. Core k uses bits `[k*ADDR_W +: ADDR_W]`.
- `i_wdata`  in  NUM_CORES*DATA_W: per-core write data, sliced the same way.
- `o_ack`  out  NUM_CORES: one-hot, one-cycle completion pulse.
- `o_rdata`  out  DATA_W: last read data, common to all cores.
- `o_grant`  out  NUM_CORES: one-hot current owner.
- `o_busy`  out  1: high while a transaction is in flight.
- `o_mem_addr`  out  ADDR_W: DRAM address.
- `o_mem_wdata`  out  DATA_W: DRAM write data.
- `o_mem_rd`  out  1: DRAM read strobe.
- `o_mem_wr`  out  1: DRAM write strobe.
- `i_mem_rdata`  in  DATA_W: DRAM read data.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - A core's request is `i_req_rd[k] | i_req_wr[k]`.
  - The winner is the first requesting index at or after `ptr`, scanning upward and wrapping past `NUM_CORES-1` to 0.
  - On a winner, latch its index, address, write data and op, then go to ISSUE.
  - If a core asserts both rd and wr, it is treated as a write.
  - With no request, stay in IDLE.
- **ISSUE** lasts one cycle.
  - Drive `o_mem_addr` and `o_mem_wdata` from the latched values.
  - Assert `o_mem_wr` for a write or `o_mem_rd` for a read.
  - Next state: ACK for a write; WAIT for a read, with the wait counter loaded to `MEM_LAT-1`.
- **WAIT** lasts `MEM_LAT` cycles.
  - The counter decrements each cycle.
  - In the cycle the counter is 0, capture `i_mem_rdata` into `o_rdata` and go to ACK.
- **ACK** lasts one cycle.
  - `o_ack[g]` is 1.
  - Set `ptr <= (g+1)` modulo `NUM_CORES`; `g = NUM_CORES-1` wraps to 0.
  - Return to IDLE.
- **Re-grant mask:** in the IDLE cycle immediately after ACK, core g's request is ignored. This gives the core one cycle to drop its level request.
- **Signal holding**
  - `o_rdata` holds its value until the next read capture. Writes do not change it.
  - `o_mem_addr` and `o_mem_wdata` hold the latched values from ISSUE through ACK.
  - `o_grant` is one-hot g from ISSUE through ACK and 0 in IDLE.
  - `o_busy` = (state != IDLE).
- Requests arriving while not in IDLE are held pending by the requester. Nothing is queued inside the arbiter.

## Timing
- **Reset values:** state=IDLE, `ptr`=0, wait counter=0, latched index/address/data=0.
  - Outputs in the cycle after the reset edge: `o_ack`=0, `o_grant`=0, `o_busy`=0, `o_mem_rd`=0, `o_mem_wr`=0, `o_mem_addr`=0, `o_mem_wdata`=0, `o_rdata`=0.
- **Reset mid-transaction:** the transaction is abandoned and no ack is issued. Strobes are low from the next cycle.
  - Reset has priority over every state transition.
- **Write latency:** request seen in IDLE at cycle 0 → `o_mem_wr` in cycle 1 → `o_ack` in cycle 2. A write occupies 3 cycles.
- **Read latency:** request at cycle 0 → `o_mem_rd` in cycle 1 → `i_mem_rdata` sampled at the end of cycle `1+MEM_LAT` → `o_ack` with valid `o_rdata` in cycle `MEM_LAT+2`.
- `o_mem_rd` and `o_mem_wr` are never both high, and each is high for exactly one cycle per transaction.
- **Fairness:** with all cores requesting continuously, grants rotate 0,1,…,N-1,0. Worst-case wait is (N-1) transactions.

## Structure
- **Package `dram_arb_pkg`:**
  - state enum (IDLE, ISSUE, WAIT, ACK).
  - op encoding (OP_RD, OP_WR).
  - `function clog2` for the `ptr`, index and counter widths.
- **Sub-module `rr_picker`:** combinational.
  - Inputs: request vector, `ptr`, mask vector.
  - Outputs: `found`, winner index.
  - Implementation: double-width rotate plus priority encode.
- The top-level holds the FSM, latches and wait counter.

## Test plan
- **Single write:** reset, then core 2 writes addr 0x0123 data 0xA5.
  - Expect `o_mem_wr`=1 with addr 0x0123 and wdata 0xA5 in cycle 1; `o_ack`=4'b0100 in cycle 2; `o_rdata` unchanged at 0.
- **Single read:** core 1 reads addr 0x0040 with `MEM_LAT`=2; the DRAM model returns 0x3C in cycle 3.
  - Expect `o_mem_rd` in cycle 1 and `o_ack`=4'b0010 with `o_rdata`=0x3C in cycle 4.
- **Contention:** all four cores request writes continuously from reset.
  - Expect ack order 0,1,2,3,0, with consecutive acks 3 cycles apart.
- **Mask and wrap:** `ptr`=3; cores 3 and 0 request, and core 3 holds its request one cycle after its ack.
  - Expect core 3 served, then core 0, with no back-to-back re-grant of core 3.
- **Reset mid-read:** assert `i_rst` during WAIT.
  - Expect no `o_ack`, all outputs 0 the next cycle, and `ptr`=0, so a subsequent core 0 request is granted first.
- **Rd and wr together:** core 0 asserts both.
  - Expect only `o_mem_wr` to pulse and `o_rdata` to be unchanged.
